// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RISC-V M-extension unit. One (XLEN+1)-bit add/sub
// step per cycle: shift-and-add multiply, restoring shift-and-subtract divide.
// Signed operands are converted to magnitudes up front and the sign is
// reapplied once at the end, so the datapath core is purely unsigned.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [CW-1:0]   counter;
    logic            neg_res;
    logic [2*XLEN:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] divisor;

    logic            is_div;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN:0] mul_next;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_res;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

    // Operand decode, magnitude conversion, single-step datapath and final sign fix-up.
    always_comb begin
        is_div      = op_q[2];
        sign_a      = a_q[XLEN-1] & ((op_q == OP_MULH) | (op_q == OP_MULHSU) |
                                     (op_q == OP_DIV) | (op_q == OP_REM));
        sign_b      = b_q[XLEN-1] & ((op_q == OP_MULH) | (op_q == OP_DIV) | (op_q == OP_REM));
        mag_a       = sign_a ? (~a_q + 1'b1) : a_q;
        mag_b       = sign_b ? (~b_q + 1'b1) : b_q;
        special     = 1'b0;
        special_res = '0;
        if (is_div && (b_q == '0)) begin
            special     = 1'b1;
            special_res = op_q[1] ? a_q : ALL_ONES;
        end else if (((op_q == OP_DIV) || (op_q == OP_REM)) &&
                     (a_q == MIN_NEG) && (b_q == ALL_ONES)) begin
            special     = 1'b1;
            special_res = op_q[1] ? '0 : MIN_NEG;
        end

        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
        mul_next = acc[0] ? ({mul_sum, acc[XLEN-1:0]} >> 1) : (acc >> 1);

        rem_sh = {rem, quo[XLEN-1]};
        trial  = rem_sh - {1'b0, divisor};

        prod_fix = neg_res ? (~acc[2*XLEN-1:0] + 1'b1) : acc[2*XLEN-1:0];
        quo_fix  = neg_res ? (~quo + 1'b1) : quo;
        rem_fix  = neg_res ? (~rem + 1'b1) : rem;

        if (is_div) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Sequencer: accept, prepare magnitudes, iterate XLEN steps, fix sign, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            counter <= '0;
            neg_res <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            result  <= '0;
        end else if (kill) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    acc     <= {{(XLEN+1){1'b0}}, mag_b};
                    mcand   <= mag_a;
                    quo     <= mag_a;
                    divisor <= mag_b;
                    rem     <= '0;
                    neg_res <= (is_div && op_q[1]) ? sign_a : (sign_a ^ sign_b);
                    if (special) begin
                        result <= special_res;
                        state  <= S_DONE;
                    end else begin
                        counter <= CW'(XLEN - 1);
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        if (!trial[XLEN]) begin
                            rem <= trial[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_next;
                    end
                    if (counter == '0) begin
                        state <= S_FIX;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                S_FIX: begin
                    result <= fix_res;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
